// File: rtl/fetch_unit_if.sv
// Fetch-unit signal bundle: instruction-memory request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_unit_if;
  logic [31:0] imem_pc_op;
  logic [31:0] imem_instr_ip;
  logic        redirect_ip;
  logic [31:0] redirect_pc_ip;
  logic        if_valid_op;
  logic [31:0] if_pc_op;
  logic [31:0] if_instr_op;
  logic        if_ready_ip;

  modport master (
    output imem_pc_op, if_valid_op, if_pc_op, if_instr_op,
    input  imem_instr_ip, redirect_ip, redirect_pc_ip, if_ready_ip
  );

  modport slave (
    input  imem_pc_op, if_valid_op, if_pc_op, if_instr_op,
    output imem_instr_ip, redirect_ip, redirect_pc_ip, if_ready_ip
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues one read per cycle to a 1-cycle memory, buffers
// returned words with their PCs in a small FIFO and hands them to decode; supports redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0]     pc_q;
  logic [31:0]     issued_pc_q;
  logic            issue_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [31:0]     pc_mem    [BUF_DEPTH];
  logic [31:0]     instr_mem [BUF_DEPTH];

  logic [31:0]     fetch_pc;
  logic            head_valid;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CntW-1:0] credit;

  always_comb begin
    fetch_pc   = bus.redirect_ip ? {bus.redirect_pc_ip[31:2], 2'b00} : pc_q;
    head_valid = (count_q != '0);
    pop        = head_valid & bus.if_ready_ip & ~bus.redirect_ip;
    push       = issue_q & ~bus.redirect_ip;
    // Occupancy including the word still in flight; pop implies count_q >= 1, so no underflow.
    credit     = count_q + CntW'(issue_q) - CntW'(pop);
    issue      = bus.redirect_ip | (credit < CntW'(BUF_DEPTH));
  end

  assign bus.imem_pc_op  = fetch_pc;
  assign bus.if_valid_op = head_valid;
  assign bus.if_pc_op    = head_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign bus.if_instr_op = head_valid ? instr_mem[rd_ptr_q] : Nop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      issued_pc_q <= 32'h0;
      issue_q     <= 1'b0;
    end else begin
      issue_q <= issue;
      if (issue) begin
        pc_q        <= fetch_pc + 32'd4;
        issued_pc_q <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (bus.redirect_ip) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: entries are only read while count_q marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= issued_pc_q;
      instr_mem[wr_ptr_q] <= bus.imem_instr_ip;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (count_q < CntW'(BUF_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, back-pressure, redirect,
// PC wrap (second instance with high RESET_PC) and asynchronous reset.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fetch_unit_if bus ();
  fetch_unit_if bus_hi ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .BUF_DEPTH (2)
  ) u_dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: Mem[i] = i, returned the cycle after the address edge.
  always @(posedge clk) begin
    bus.imem_instr_ip    <= {2'b00, bus.imem_pc_op[31:2]};
    bus_hi.imem_instr_ip <= {2'b00, bus_hi.imem_pc_op[31:2]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] hi_pc    [4];
  logic [31:0] hi_instr [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    hi_pc    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    hi_instr = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst                   = 1'b1;
    bus.redirect_ip       = 1'b0;
    bus.redirect_pc_ip    = 32'h0;
    bus.if_ready_ip       = 1'b1;
    bus_hi.redirect_ip    = 1'b0;
    bus_hi.redirect_pc_ip = 32'h0;
    bus_hi.if_ready_ip    = 1'b1;
    step();
    step();

    // Reset state
    check_eq("rst_imem_pc", bus.imem_pc_op, 32'h0);
    check_eq("rst_valid", {31'h0, bus.if_valid_op}, 32'h0);
    check_eq("rst_if_pc", bus.if_pc_op, 32'h0);
    check_eq("rst_instr", bus.if_instr_op, 32'h13);
    check_eq("rst_hi_imem_pc", bus_hi.imem_pc_op, 32'hFFFF_FFF8);

    // Streaming from reset, plus wrap on the high-PC instance
    rst = 1'b0;
    step();
    check_eq("t1_valid_e1", {31'h0, bus.if_valid_op}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t1_valid", {31'h0, bus.if_valid_op}, 32'h1);
      check_eq("t1_pc", bus.if_pc_op, 32'(i * 4));
      check_eq("t1_instr", bus.if_instr_op, 32'(i));
      check_eq("t5_hi_pc", bus_hi.if_pc_op, hi_pc[i]);
      check_eq("t5_hi_instr", bus_hi.if_instr_op, hi_instr[i]);
    end

    // Back-pressure: head holds at 0xC, fetch stalls at 0x14
    bus.if_ready_ip = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("t2_hold_valid", {31'h0, bus.if_valid_op}, 32'h1);
      check_eq("t2_hold_pc", bus.if_pc_op, 32'hC);
      check_eq("t2_hold_instr", bus.if_instr_op, 32'h3);
    end
    check_eq("t2_stall_imem_pc", bus.imem_pc_op, 32'h14);
    bus.if_ready_ip = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t2_resume_pc", bus.if_pc_op, 32'(32'h10 + k * 4));
      check_eq("t2_resume_instr", bus.if_instr_op, 32'(4 + k));
    end

    // Redirect with a buffered head and a word in flight; low bits of target ignored
    bus.redirect_ip    = 1'b1;
    bus.redirect_pc_ip = 32'h43;
    #1;
    check_eq("t4_imem_pc_redirect", bus.imem_pc_op, 32'h40);
    check_eq("t3_head_unchanged", bus.if_pc_op, 32'h18);
    step();
    bus.redirect_ip = 1'b0;
    check_eq("t3_flushed_valid", {31'h0, bus.if_valid_op}, 32'h0);
    check_eq("t3_flushed_instr", bus.if_instr_op, 32'h13);
    step();
    check_eq("t3_tgt_valid", {31'h0, bus.if_valid_op}, 32'h1);
    check_eq("t3_tgt_pc", bus.if_pc_op, 32'h40);
    check_eq("t3_tgt_instr", bus.if_instr_op, 32'h10);
    step();
    check_eq("t3_next_pc", bus.if_pc_op, 32'h44);

    // Back-to-back redirects: the later one wins
    bus.redirect_ip    = 1'b1;
    bus.redirect_pc_ip = 32'h100;
    step();
    check_eq("t3b_valid_mid", {31'h0, bus.if_valid_op}, 32'h0);
    bus.redirect_pc_ip = 32'h200;
    step();
    bus.redirect_ip = 1'b0;
    check_eq("t3b_valid_last", {31'h0, bus.if_valid_op}, 32'h0);
    step();
    check_eq("t3b_pc", bus.if_pc_op, 32'h200);
    check_eq("t3b_instr", bus.if_instr_op, 32'h80);
    step();

    // Asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    check_eq("t6_valid", {31'h0, bus.if_valid_op}, 32'h0);
    check_eq("t6_instr", bus.if_instr_op, 32'h13);
    check_eq("t6_if_pc", bus.if_pc_op, 32'h0);
    check_eq("t6_imem_pc", bus.imem_pc_op, 32'h0);
    check_eq("t6_hi_imem_pc", bus_hi.imem_pc_op, 32'hFFFF_FFF8);
    step();
    rst = 1'b0;
    step();
    check_eq("t6_valid_e1", {31'h0, bus.if_valid_op}, 32'h0);
    step();
    check_eq("t6_restart_valid", {31'h0, bus.if_valid_op}, 32'h1);
    check_eq("t6_restart_pc", bus.if_pc_op, 32'h0);
    check_eq("t6_restart_instr", bus.if_instr_op, 32'h0);
    check_eq("t6_hi_restart_pc", bus_hi.if_pc_op, 32'hFFFF_FFF8);
    step();
    check_eq("t6_next_pc", bus.if_pc_op, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
